// File: rtl/sync_down_timer_if.sv
// Control and status bundle for sync_down_timer.
// The master drives the control inputs and watches the count; the timer is the slave.
interface sync_down_timer_if #(
    parameter int WIDTH = 4
);
    logic             start;
    logic             stop;
    logic             en;
    logic             periodic;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] q;
    logic             busy;
    logic             done;
    logic             tc;

    modport master (
        output start, stop, en, periodic, load_val,
        input  q, busy, done, tc
    );

    modport slave (
        input  start, stop, en, periodic, load_val,
        output q, busy, done, tc
    );
endinterface

// File: rtl/sync_down_timer.sv
// Loadable down-counter with one-shot and auto-reload modes and a one-cycle terminal-count pulse.
// Used as the interval/timeout generator next to the up-counters.
module sync_down_timer #(
    parameter int WIDTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    sync_down_timer_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] count;
    logic [WIDTH-1:0] count_next;
    logic [WIDTH-1:0] reload;
    logic [WIDTH-1:0] reload_next;
    logic             mode;
    logic             mode_next;
    logic             tc_next;
    logic             busy_r;
    logic             done_r;
    logic             tc_r;
    logic             load_ok;

    // A zero load value is never accepted, so a start with load_val==0 falls through to lower priorities.
    assign load_ok = bus.start && (bus.load_val != '0);

    always_comb begin
        state_next  = state;
        count_next  = count;
        reload_next = reload;
        mode_next   = mode;
        tc_next     = 1'b0;

        case (state)
            IDLE: begin
                if (!bus.stop && load_ok) begin
                    count_next  = bus.load_val;
                    reload_next = bus.load_val;
                    mode_next   = bus.periodic;
                    state_next  = RUN;
                end
            end
            RUN: begin
                if (bus.stop) begin
                    state_next = IDLE;
                end else if (load_ok) begin
                    count_next  = bus.load_val;
                    reload_next = bus.load_val;
                    mode_next   = bus.periodic;
                end else if (bus.en) begin
                    if (count > WIDTH'(1)) begin
                        count_next = count - WIDTH'(1);
                    end else if (count == WIDTH'(1)) begin
                        count_next = '0;
                        tc_next    = 1'b1;
                        if (!mode) begin
                            state_next = DONE;
                        end
                    end else if (mode) begin
                        // Zero is a full count step in periodic mode: period is reload+1 ticks.
                        count_next = reload;
                    end
                end
            end
            DONE: begin
                if (bus.stop) begin
                    state_next = IDLE;
                    count_next = '0;
                end else if (load_ok) begin
                    count_next  = bus.load_val;
                    reload_next = bus.load_val;
                    mode_next   = bus.periodic;
                    state_next  = RUN;
                end
            end
            default: begin
                state_next = IDLE;
                count_next = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            count  <= '0;
            reload <= '0;
            mode   <= 1'b0;
            busy_r <= 1'b0;
            done_r <= 1'b0;
            tc_r   <= 1'b0;
        end else begin
            state  <= state_next;
            count  <= count_next;
            reload <= reload_next;
            mode   <= mode_next;
            busy_r <= (state_next == RUN);
            done_r <= (state_next == DONE);
            tc_r   <= tc_next;
        end
    end

    assign bus.q    = count;
    assign bus.busy = busy_r;
    assign bus.done = done_r;
    assign bus.tc   = tc_r;

endmodule

// File: tb/tb_sync_down_timer.sv
// Self-checking bench for sync_down_timer: expected outputs are queued as stimulus is driven
// and compared on the following falling edge, after the DUT has registered the cycle.
module tb_sync_down_timer;

    localparam int WIDTH = 4;

    typedef struct packed {
        logic [WIDTH-1:0] q;
        logic             busy;
        logic             done;
        logic             tc;
    } exp_t;

    typedef struct packed {
        logic             rst;
        logic             start;
        logic             stop;
        logic             en;
        logic             periodic;
        logic [WIDTH-1:0] load_val;
        exp_t             exp;
    } row_t;

    logic clk;
    logic rst;
    int   checks;
    int   passes;
    exp_t sb[$];

    sync_down_timer_if #(.WIDTH(WIDTH)) bus ();

    sync_down_timer #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic row_t mk(input logic r, input logic s, input logic st, input logic e,
                                input logic p, input logic [WIDTH-1:0] lv,
                                input logic [WIDTH-1:0] eq, input logic eb, input logic ed,
                                input logic et);
        row_t row;
        row.rst      = r;
        row.start    = s;
        row.stop     = st;
        row.en       = e;
        row.periodic = p;
        row.load_val = lv;
        row.exp      = '{q: eq, busy: eb, done: ed, tc: et};
        return row;
    endfunction

    // Drives one cycle of inputs (called just after a falling edge) and queues the expected result.
    task automatic applyStimulus(input row_t row);
        rst          = row.rst;
        bus.start    = row.start;
        bus.stop     = row.stop;
        bus.en       = row.en;
        bus.periodic = row.periodic;
        bus.load_val = row.load_val;
        sb.push_back(row.exp);
    endtask

    task automatic test_reset();
        row_t rows[$];
        exp_t exp;
        exp_t got;
        rows.push_back(mk(1, 1, 0, 1, 0, 4'd9, 4'd0, 0, 0, 0));
        rows.push_back(mk(1, 1, 0, 1, 0, 4'd9, 4'd0, 0, 0, 0));
        rows.push_back(mk(0, 0, 0, 1, 0, 4'd9, 4'd0, 0, 0, 0));
        rows.push_back(mk(0, 0, 0, 0, 0, 4'd0, 4'd0, 0, 0, 0));
        foreach (rows[i]) begin
            applyStimulus(rows[i]);
            @(negedge clk);
            exp = sb.pop_front();
            got = '{q: bus.q, busy: bus.busy, done: bus.done, tc: bus.tc};
            checks++;
            if (got !== exp)
                $display("[TB] FAIL reset[%0d]: got q=%0d busy=%b done=%b tc=%b, want q=%0d busy=%b done=%b tc=%b",
                         i, got.q, got.busy, got.done, got.tc, exp.q, exp.busy, exp.done, exp.tc);
            else
                passes++;
        end
    endtask

    task automatic test_one_shot();
        row_t rows[$];
        exp_t exp;
        exp_t got;
        rows.push_back(mk(0, 1, 0, 1, 0, 4'd5, 4'd5, 1, 0, 0));
        for (int v = 4; v >= 1; v--)
            rows.push_back(mk(0, 0, 0, 1, 0, 4'd0, 4'(v), 1, 0, 0));
        rows.push_back(mk(0, 0, 0, 1, 0, 4'd0, 4'd0, 0, 1, 1));
        for (int k = 0; k < 10; k++)
            rows.push_back(mk(0, 0, 0, 1, 0, 4'd0, 4'd0, 0, 1, 0));
        foreach (rows[i]) begin
            applyStimulus(rows[i]);
            @(negedge clk);
            exp = sb.pop_front();
            got = '{q: bus.q, busy: bus.busy, done: bus.done, tc: bus.tc};
            checks++;
            if (got !== exp)
                $display("[TB] FAIL one_shot[%0d]: got q=%0d busy=%b done=%b tc=%b, want q=%0d busy=%b done=%b tc=%b",
                         i, got.q, got.busy, got.done, got.tc, exp.q, exp.busy, exp.done, exp.tc);
            else
                passes++;
        end
    endtask

    task automatic test_periodic();
        row_t rows[$];
        exp_t exp;
        exp_t got;
        int   v;
        rows.push_back(mk(0, 1, 0, 1, 1, 4'd3, 4'd3, 1, 0, 0));
        for (int k = 1; k <= 8; k++) begin
            v = 3 - (k % 4);
            rows.push_back(mk(0, 0, 0, 1, 0, 4'd0, 4'(v), 1, 0, (v == 0)));
        end
        rows.push_back(mk(0, 0, 1, 1, 0, 4'd0, 4'd3, 0, 0, 0));
        foreach (rows[i]) begin
            applyStimulus(rows[i]);
            @(negedge clk);
            exp = sb.pop_front();
            got = '{q: bus.q, busy: bus.busy, done: bus.done, tc: bus.tc};
            checks++;
            if (got !== exp)
                $display("[TB] FAIL periodic[%0d]: got q=%0d busy=%b done=%b tc=%b, want q=%0d busy=%b done=%b tc=%b",
                         i, got.q, got.busy, got.done, got.tc, exp.q, exp.busy, exp.done, exp.tc);
            else
                passes++;
        end
    endtask

    task automatic test_gated_enable();
        row_t rows[$];
        exp_t exp;
        exp_t got;
        logic [WIDTH-1:0] want [7] = '{4'd3, 4'd3, 4'd2, 4'd2, 4'd1, 4'd1, 4'd0};
        rows.push_back(mk(0, 1, 0, 1, 0, 4'd4, 4'd4, 1, 0, 0));
        for (int k = 0; k < 7; k++)
            rows.push_back(mk(0, 0, 0, ((k % 2) == 0), 0, 4'd0, want[k],
                              (k != 6), (k == 6), (k == 6)));
        rows.push_back(mk(0, 0, 0, 0, 0, 4'd0, 4'd0, 0, 1, 0));
        rows.push_back(mk(0, 0, 1, 0, 0, 4'd0, 4'd0, 0, 0, 0));
        foreach (rows[i]) begin
            applyStimulus(rows[i]);
            @(negedge clk);
            exp = sb.pop_front();
            got = '{q: bus.q, busy: bus.busy, done: bus.done, tc: bus.tc};
            checks++;
            if (got !== exp)
                $display("[TB] FAIL gated_en[%0d]: got q=%0d busy=%b done=%b tc=%b, want q=%0d busy=%b done=%b tc=%b",
                         i, got.q, got.busy, got.done, got.tc, exp.q, exp.busy, exp.done, exp.tc);
            else
                passes++;
        end
    endtask

    task automatic test_collisions();
        row_t rows[$];
        exp_t exp;
        exp_t got;
        rows.push_back(mk(0, 1, 0, 1, 0, 4'd10, 4'd10, 1, 0, 0));
        for (int v = 9; v >= 6; v--)
            rows.push_back(mk(0, 0, 0, 1, 0, 4'd0, 4'(v), 1, 0, 0));
        rows.push_back(mk(0, 1, 1, 1, 0, 4'd10, 4'd6, 0, 0, 0));
        rows.push_back(mk(0, 1, 0, 1, 0, 4'd0, 4'd6, 0, 0, 0));
        rows.push_back(mk(0, 1, 0, 1, 0, 4'd4, 4'd4, 1, 0, 0));
        rows.push_back(mk(0, 0, 0, 1, 0, 4'd0, 4'd3, 1, 0, 0));
        rows.push_back(mk(0, 0, 0, 1, 0, 4'd0, 4'd2, 1, 0, 0));
        rows.push_back(mk(0, 1, 0, 1, 0, 4'd7, 4'd7, 1, 0, 0));
        rows.push_back(mk(0, 0, 0, 1, 0, 4'd0, 4'd6, 1, 0, 0));
        rows.push_back(mk(0, 1, 0, 1, 0, 4'd0, 4'd5, 1, 0, 0));
        rows.push_back(mk(0, 0, 1, 1, 0, 4'd0, 4'd5, 0, 0, 0));
        foreach (rows[i]) begin
            applyStimulus(rows[i]);
            @(negedge clk);
            exp = sb.pop_front();
            got = '{q: bus.q, busy: bus.busy, done: bus.done, tc: bus.tc};
            checks++;
            if (got !== exp)
                $display("[TB] FAIL collisions[%0d]: got q=%0d busy=%b done=%b tc=%b, want q=%0d busy=%b done=%b tc=%b",
                         i, got.q, got.busy, got.done, got.tc, exp.q, exp.busy, exp.done, exp.tc);
            else
                passes++;
        end
    endtask

    task automatic test_reset_mid_and_max();
        row_t rows[$];
        exp_t exp;
        exp_t got;
        int   v;
        rows.push_back(mk(0, 1, 0, 1, 1, 4'd15, 4'd15, 1, 0, 0));
        for (int k = 14; k >= 2; k--)
            rows.push_back(mk(0, 0, 0, 1, 0, 4'd0, 4'(k), 1, 0, 0));
        rows.push_back(mk(1, 0, 0, 1, 0, 4'd0, 4'd0, 0, 0, 0));
        rows.push_back(mk(0, 0, 0, 1, 0, 4'd0, 4'd0, 0, 0, 0));
        rows.push_back(mk(0, 1, 0, 1, 1, 4'd15, 4'd15, 1, 0, 0));
        for (int k = 1; k <= 32; k++) begin
            v = 15 - (k % 16);
            rows.push_back(mk(0, 0, 0, 1, 0, 4'd0, 4'(v), 1, 0, (v == 0)));
        end
        foreach (rows[i]) begin
            applyStimulus(rows[i]);
            @(negedge clk);
            exp = sb.pop_front();
            got = '{q: bus.q, busy: bus.busy, done: bus.done, tc: bus.tc};
            checks++;
            if (got !== exp)
                $display("[TB] FAIL max_reset[%0d]: got q=%0d busy=%b done=%b tc=%b, want q=%0d busy=%b done=%b tc=%b",
                         i, got.q, got.busy, got.done, got.tc, exp.q, exp.busy, exp.done, exp.tc);
            else
                passes++;
        end
    endtask

    initial begin
        checks       = 0;
        passes       = 0;
        rst          = 1'b1;
        bus.start    = 1'b0;
        bus.stop     = 1'b0;
        bus.en       = 1'b0;
        bus.periodic = 1'b0;
        bus.load_val = '0;
        @(negedge clk);

        test_reset();
        test_one_shot();
        test_periodic();
        test_gated_enable();
        test_collisions();
        test_reset_mid_and_max();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
